// File: rtl/sqrt_arbiter_if.sv
// Request/response bundle between NREQ root requesters, the shared square-root
// engine and the downstream result consumer.
interface sqrt_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [32*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic [15:0]          rsp_data;
  logic [IDW-1:0]       rsp_id;
  logic                 rsp_ready;
  logic                 busy;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/sqrt_arbiter.sv
// Round-robin shared integer square-root engine: one 32-bit operand at a time,
// four restoring root bits per cycle, result tagged with the requester index.
module sqrt_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic          clock,
  input  logic          reset,
  sqrt_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      r_state;
  logic [IDW-1:0]  r_last;
  logic [31:0]     r_op;
  logic [17:0]     r_rem;
  logic [15:0]     r_root;
  logic [1:0]      r_cnt;
  logic [15:0]     r_rspData;
  logic [IDW-1:0]  r_rspId;

  logic [IDW-1:0]  w_grant;
  logic [IDW-1:0]  w_idx;
  logic            w_found;
  logic [NREQ-1:0] w_ready;
  logic [31:0]     w_operand;

  logic [19:0]     w_trial;
  logic [17:0]     w_rem;
  logic [15:0]     w_root;
  logic [31:0]     w_op;
  logic            w_unusedTrial;

  // Scan downward so the closest requester after r_last is written last and wins.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = IDW'((int'(r_last) + k) % NREQ);
      if (bus.req_valid[w_idx]) begin
        w_grant = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_operand = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant == IDW'(i)) begin
        w_operand = bus.req_data[i*32 +: 32];
      end
    end
  end

  assign w_ready = (r_state == S_IDLE && w_found && !reset) ? (NREQ'(1) << w_grant) : '0;

  // Four restoring steps; the trial is kept wide enough that bit 19 is a true sign.
  always_comb begin
    w_rem         = r_rem;
    w_root        = r_root;
    w_op          = r_op;
    w_trial       = '0;
    w_unusedTrial = 1'b0;
    for (int s = 0; s < 4; s++) begin
      w_trial       = {w_rem, w_op[31:30]} - {2'b00, w_root, 2'b01};
      w_unusedTrial = w_unusedTrial ^ w_trial[18];
      if (!w_trial[19]) begin
        w_rem  = w_trial[17:0];
        w_root = {w_root[14:0], 1'b1};
      end else begin
        w_rem  = {w_rem[15:0], w_op[31:30]};
        w_root = {w_root[14:0], 1'b0};
      end
      w_op = {w_op[29:0], 2'b00};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_last    <= IDW'(NREQ - 1);
      r_op      <= '0;
      r_rem     <= '0;
      r_root    <= '0;
      r_cnt     <= '0;
      r_rspData <= '0;
      r_rspId   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_op    <= w_operand;
            r_rspId <= w_grant;
            r_last  <= w_grant;
            r_rem   <= '0;
            r_root  <= '0;
            r_cnt   <= '0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_op   <= w_op;
          r_rem  <= w_rem;
          r_root <= w_root;
          r_cnt  <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_rspData <= w_root;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = (r_state == S_DONE);
  assign bus.rsp_data  = r_rspData;
  assign bus.rsp_id    = r_rspId;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Self-checking bench for sqrt_arbiter: directed scenarios plus a random
// regression, all compared against a cycle-level behavioural reference model.
module tb_sqrt_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sqrt_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  sqrt_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int isqrt(input longint x);
    longint lo, hi, mid;
    lo = 0;
    hi = 65536;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid;
    end
    return int'(lo);
  endfunction

  function automatic int rrPick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // Reference model: mState 0 = idle, 1..4 = computing, 5 = holding a result.
  int mState = 0;
  int mLast  = NREQ - 1;
  int mExpRoot, mExpId;
  int abortCount = 0;
  int dutHs = 0;
  int dutRsp = 0;
  int cyc = 0;
  int rspIdLog[$];
  int rspCycLog[$];

  always @(posedge clock) cyc++;

  always @(negedge clock) begin : monitor
    int g;
    logic [NREQ-1:0] er;
    if (reset) begin
      if (mState != 0) abortCount++;
      mState = 0;
      mLast  = NREQ - 1;
    end else begin
      if ((bus.req_ready & bus.req_valid) != '0) dutHs++;
      if (bus.rsp_valid && bus.rsp_ready) dutRsp++;
      if (mState == 0) begin
        g  = rrPick(bus.req_valid, mLast);
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        checkOutput("idle_req_ready", bus.req_ready, er);
        checkOutput("idle_busy", bus.busy, 0);
        checkOutput("idle_rsp_valid", bus.rsp_valid, 0);
        if (g >= 0) begin
          mExpRoot = isqrt(longint'(bus.req_data[g*32 +: 32]));
          mExpId   = g;
          mLast    = g;
          mState   = 1;
        end
      end else if (mState < 5) begin
        checkOutput("calc_req_ready", bus.req_ready, 0);
        checkOutput("calc_busy", bus.busy, 1);
        checkOutput("calc_rsp_valid", bus.rsp_valid, 0);
        mState++;
      end else begin
        checkOutput("done_req_ready", bus.req_ready, 0);
        checkOutput("done_busy", bus.busy, 1);
        checkOutput("done_rsp_valid", bus.rsp_valid, 1);
        checkOutput("done_rsp_data", bus.rsp_data, mExpRoot);
        checkOutput("done_rsp_id", bus.rsp_id, mExpId);
        if (bus.rsp_ready) begin
          rspIdLog.push_back(mExpId);
          rspCycLog.push_back(cyc);
          mState = 0;
        end
      end
    end
  end

  task automatic waitIdle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!bus.busy) return;
    end
    checkOutput("wait_idle_timeout", bus.busy, 0);
  endtask

  task automatic waitGrant(input string tag, input logic [NREQ-1:0] expReady);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.req_ready != '0) break;
    end
    checkOutput({tag, "_grant"}, bus.req_ready, expReady);
  endtask

  task automatic applyStimulus(input int id, input logic [31:0] operand,
                               input logic [15:0] expRoot, input string tag);
    logic [NREQ-1:0] oneHot;
    oneHot     = '0;
    oneHot[id] = 1'b1;
    bus.req_data[id*32 +: 32] = operand;
    bus.req_valid = oneHot;
    bus.rsp_ready = 1'b1;
    waitGrant(tag, oneHot);
    @(posedge clock); #1;
    bus.req_valid = '0;
    checkOutput({tag, "_ready_pulse"}, bus.req_ready, 0);
    repeat (3) @(posedge clock);
    #1;
    checkOutput({tag, "_early_valid"}, bus.rsp_valid, 0);
    @(posedge clock); #1;
    checkOutput({tag, "_rsp_valid"}, bus.rsp_valid, 1);
    checkOutput({tag, "_rsp_data"}, bus.rsp_data, expRoot);
    checkOutput({tag, "_rsp_id"}, bus.rsp_id, id);
    waitIdle();
  endtask

  logic [31:0] edgeOps [6] = '{32'h0, 32'd15, 32'd16, 32'hFFFFFFFF, 32'hFFFE0001, 32'hFFFE0000};
  logic [15:0] edgeExp [6] = '{16'h0, 16'h3, 16'h4, 16'hFFFF, 16'hFFFF, 16'hFFFE};
  logic [31:0] randEdge [6] = '{32'h0, 32'hFFFFFFFF, 32'hFFFE0001, 32'hFFFE0000, 32'd1, 32'd3};

  initial begin : watchdog
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req_valid = '1;
    bus.req_data  = {32'h40000000, 32'd1000000, 32'd10000, 32'd100};
    bus.rsp_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_rsp_valid", bus.rsp_valid, 0);
    checkOutput("reset_rsp_data", bus.rsp_data, 0);
    checkOutput("reset_rsp_id", bus.rsp_id, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_req_ready", bus.req_ready, 0);

    // Fairness: everybody valid from the first cycle out of reset.
    rspIdLog.delete();
    rspCycLog.delete();
    reset = 1'b0;
    repeat (32) @(posedge clock);
    #1;
    bus.req_valid = '0;
    waitIdle();
    checkOutput("fair_count_ok", rspIdLog.size() >= 5, 1);
    for (int i = 0; i < 5 && i < rspIdLog.size(); i++) begin
      checkOutput("fair_id", rspIdLog[i], i % NREQ);
      if (i > 0) checkOutput("fair_spacing", rspCycLog[i] - rspCycLog[i-1], 6);
    end

    applyStimulus(2, 32'h00010000, 16'h0100, "single");
    for (int i = 0; i < 6; i++) applyStimulus(0, edgeOps[i], edgeExp[i], "edge");

    // Backpressure: the result must be frozen while the consumer stalls.
    bus.req_data[1*32 +: 32] = 32'd1000000;
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.rsp_valid) break;
    end
    @(posedge clock); #1;
    bus.req_valid = 4'b1101;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checkOutput("bp_rsp_valid", bus.rsp_valid, 1);
      checkOutput("bp_rsp_data", bus.rsp_data, 16'd1000);
      checkOutput("bp_rsp_id", bus.rsp_id, 1);
      checkOutput("bp_busy", bus.busy, 1);
      checkOutput("bp_req_ready", bus.req_ready, 0);
    end
    @(posedge clock); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checkOutput("bp_back_idle", bus.busy, 0);
    checkOutput("bp_next_grant", bus.req_ready, 4'b0100);
    @(posedge clock); #1;
    bus.req_valid = '0;
    waitIdle();

    // Reset in the third compute cycle aborts the job and rewinds the pointer.
    bus.req_data[0 +: 32] = 32'h12345678;
    bus.req_valid = 4'b0001;
    waitGrant("rst_job", 4'b0001);
    @(posedge clock); #1;
    bus.req_valid = '0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_rsp_valid", bus.rsp_valid, 0);
    checkOutput("rst_mid_busy", bus.busy, 0);
    checkOutput("rst_mid_req_ready", bus.req_ready, 0);
    checkOutput("rst_mid_rsp_data", bus.rsp_data, 0);
    checkOutput("rst_mid_rsp_id", bus.rsp_id, 0);
    bus.req_data[1*32 +: 32] = 32'd49;
    bus.req_data[3*32 +: 32] = 32'd81;
    bus.req_valid = 4'b1010;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rst_regrant", bus.req_ready, 4'b0010);
    @(posedge clock); #1;
    bus.req_valid = '0;
    waitIdle();

    // Random regression with valid drops, operand changes and consumer stalls.
    for (int c = 0; c < 20000; c++) begin
      @(posedge clock); #1;
      for (int i = 0; i < NREQ; i++) begin
        bus.req_valid[i] = ($urandom_range(0, 99) < 60);
        if ($urandom_range(0, 7) == 0)
          bus.req_data[i*32 +: 32] = randEdge[$urandom_range(0, 5)];
        else
          bus.req_data[i*32 +: 32] = $urandom;
      end
      bus.rsp_ready = ($urandom_range(0, 99) < 70);
    end
    @(posedge clock); #1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    waitIdle();
    checkOutput("no_loss_or_dup", dutRsp, dutHs - abortCount);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
